readline_arbiter: RTL and testbench
===================================

// Module: readline_arbiter
// PURPOSE
// - Shares one 128-bit readline port (memory side) between two requesters: port 0 (code prefetch), port 1 (data read).
// - Sits between the requesters' readline link stages and the single memory-side readline link.
// - Arbitrates, registers and holds the winning address, tracks the single outstanding line read, routes done/line back.
// PARAMETERS
// - FIXED_PRIO   default 0   0: round-robin between ports; 1: port 0 always wins a simultaneous request
// - LINE_LSB     default 4   address bits [LINE_LSB-1:0] forced to 0 on the memory side (16-byte line)
// PORTS
// - clk                 in   1    single clock; all state on posedge
// - rst                 in   1    reset, synchronous, active-high
// - req0_readline_do    in   1    port 0 request; held high until req0_readline_done
// - req0_readline_address in 32   port 0 line address; stable while do high
// - req0_readline_done  out  1    port 0 one-cycle completion pulse
// - req0_readline_line  out  128  port 0 line data, valid with done
// - req1_*              -    -    identical set for port 1
// - resp_readline_do    out  1    memory-side request, registered, held until resp_readline_done
// - resp_readline_address out 32  memory-side aligned address, registered
// - resp_readline_done  in   1    memory-side one-cycle completion pulse
// - resp_readline_line  in   128  memory-side line, valid with resp_readline_done
// BEHAVIOUR
// - Reset: state IDLE; resp_readline_do=0; resp_readline_address=0; last_grant=1 (port 0 first); req*_done=0.
// - States: IDLE, BUSY0, BUSY1 (BUSYn = line read outstanding for port n).
// - IDLE: if any reqN_do: choose winner (FIXED_PRIO=1 -> port 0; else the port != last_grant when both high,
//   the only requester otherwise); next cycle state=BUSYn, resp_readline_do=1,
//   resp_readline_address={reqN_address[31:LINE_LSB], LINE_LSB'b0}, last_grant=n. Latency do->resp_do: 1 cycle.
// - BUSYn: resp_readline_do and address held constant; other port's request waits (no preemption).
//   On resp_readline_done: reqN_readline_done = resp_readline_done & reqN_readline_do (combinational, same cycle);
//   reqN_readline_line = resp_readline_line (pass-through, both ports see line; only done is steered);
//   next cycle state=IDLE, resp_readline_do=0.
// - Back-to-back: done cycle -> IDLE (1 cycle gap) -> next grant; min 2 cycles between memory requests.
// - Abandon: requester drops do while BUSYn -> memory read still completes, done swallowed (not forwarded);
//   arbiter returns to IDLE normally. Never issue a second memory request while one is outstanding.
// - resp_readline_done in IDLE (spurious): ignored, no req*_done pulse.
// - req done outputs never high outside BUSYn done cycle; never both high.
// - Reset mid-read: state->IDLE, resp_readline_do=0 next cycle; a late resp_readline_done is ignored (IDLE rule).
// - Address change while BUSY: ignored; registered address is authoritative.
// STRUCTURE
// - Shared defines: `TRUE/`FALSE, state encodings STATE_IDLE/STATE_BUSY0/STATE_BUSY1 (2 bits).
// - One natural sub-module: readline_rr_pick (2-way round-robin/fixed picker: req[1:0], last_grant, FIXED_PRIO -> grant[1:0]).
// - Rest is flat: state register, last_grant flop, address register, done steering.
// TESTING
// - Single: req0 do, addr 0x0001_2345 -> cycle+1 resp_do=1, resp_addr 0x0001_2340; done with line L -> req0_done=1, line L, req1_done=0.
// - Contention RR: req0,req1 high same cycle from reset -> port0 served first, then port1 at 0x0000_8000 after 1-cycle IDLE gap.
// - Contention FIXED_PRIO=1: port0 re-requests continuously -> port1 starves; FIXED_PRIO=0 -> strict alternation 0,1,0,1.
// - Abandon: req1 drops do 2 cycles into BUSY1 -> resp_done pulse produces no req1_done; next req0 granted normally.
// - Reset mid-read: rst during BUSY0 -> resp_do=0 next cycle; later resp_done -> no done pulse, state IDLE.
// - Spurious resp_done in IDLE and address wiggle during BUSY -> no outputs change, resp_addr stays latched.

Source files
------------

// File: rtl/readline_arbiter_pkg.sv
// Shared types and helpers for the two-port readline arbiter.
package readline_arbiter_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned LineW = 128;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusy0 = 2'b01,
    StBusy1 = 2'b10
  } state_e;

  // Clear the in-line offset bits so memory only ever sees line-aligned addresses.
  function automatic logic [AddrW-1:0] line_align(input logic [AddrW-1:0] addr,
                                                  input int unsigned lsb);
    logic [AddrW-1:0] mask;
    mask = {AddrW{1'b1}} << lsb;
    return addr & mask;
  endfunction

endpackage

// File: rtl/readline_rr_pick.sv
// Two-way request picker: round-robin against the last grant, or fixed priority to port 0.
module readline_rr_pick #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that was not served last wins unless port 0 has priority.
      2'b11:   grant = ((FIXED_PRIO != 0) || last_grant) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/readline_arbiter.sv
// Shares one memory-side readline port between a code-prefetch port (0) and a data port (1);
// a single line read is outstanding at a time and its completion is steered to the owner.
module readline_arbiter
  import readline_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned LINE_LSB   = 4
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_readline_do,
  input  logic [AddrW-1:0] req0_readline_address,
  output logic             req0_readline_done,
  output logic [LineW-1:0] req0_readline_line,

  input  logic             req1_readline_do,
  input  logic [AddrW-1:0] req1_readline_address,
  output logic             req1_readline_done,
  output logic [LineW-1:0] req1_readline_line,

  output logic             resp_readline_do,
  output logic [AddrW-1:0] resp_readline_address,
  input  logic             resp_readline_done,
  input  logic [LineW-1:0] resp_readline_line
);

  state_e           state_q;
  logic             last_grant_q;
  logic             resp_do_q;
  logic [AddrW-1:0] resp_addr_q;

  logic [1:0]       grant;
  logic [AddrW-1:0] pick_addr;

  readline_rr_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .req       ({req1_readline_do, req0_readline_do}),
    .last_grant(last_grant_q),
    .grant     (grant)
  );

  always_comb begin
    pick_addr = req0_readline_address;
    if (grant[1]) begin
      pick_addr = req1_readline_address;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      resp_do_q    <= 1'b0;
      resp_addr_q  <= '0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A stray completion while idle falls through here and is dropped.
          if (grant != 2'b00) begin
            state_q      <= grant[1] ? StBusy1 : StBusy0;
            resp_do_q    <= 1'b1;
            resp_addr_q  <= line_align(pick_addr, LINE_LSB);
            last_grant_q <= grant[1];
          end
        end
        StBusy0, StBusy1: begin
          if (resp_readline_done) begin
            state_q   <= StIdle;
            resp_do_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          resp_do_q <= 1'b0;
        end
      endcase
    end
  end

  // Done is only forwarded while the owner still wants it; an abandoned read is swallowed.
  always_comb begin
    req0_readline_done = (state_q == StBusy0) && resp_readline_done && req0_readline_do;
    req1_readline_done = (state_q == StBusy1) && resp_readline_done && req1_readline_do;
  end

  assign req0_readline_line    = resp_readline_line;
  assign req1_readline_line    = resp_readline_line;
  assign resp_readline_do      = resp_do_q;
  assign resp_readline_address = resp_addr_q;

  a_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(req0_readline_done && req1_readline_done));

  a_do_held: assert property (@(posedge clk) disable iff (rst)
    (resp_readline_do && !resp_readline_done) |=> resp_readline_do);

  a_addr_held: assert property (@(posedge clk) disable iff (rst)
    (resp_readline_do && !resp_readline_done) |=> $stable(resp_readline_address));

  a_grant_onehot: assert property (@(posedge clk) $onehot0(grant));

endmodule

// File: tb/tb_readline_arbiter.sv
// Scoreboard bench: a transaction-level model predicts memory requests and steered completions.
module tb_readline_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         rq_do   [2];
  logic [31:0]  rq_addr [2];
  logic         m_done;
  logic [127:0] m_line;
  logic         r0_done, r1_done, m_do;
  logic [127:0] r0_line, r1_line;
  logic [31:0]  m_addr;

  logic         f_do   [2];
  logic [31:0]  f_addr [2];
  logic         f_mdone, f0_done, f1_done, f_mdo;
  logic [127:0] f_mline, f0_line, f1_line;
  logic [31:0]  f_maddr;

  readline_arbiter #(.FIXED_PRIO(0), .LINE_LSB(4)) u_dut (
    .clk(clk), .rst(rst),
    .req0_readline_do(rq_do[0]), .req0_readline_address(rq_addr[0]),
    .req0_readline_done(r0_done), .req0_readline_line(r0_line),
    .req1_readline_do(rq_do[1]), .req1_readline_address(rq_addr[1]),
    .req1_readline_done(r1_done), .req1_readline_line(r1_line),
    .resp_readline_do(m_do), .resp_readline_address(m_addr),
    .resp_readline_done(m_done), .resp_readline_line(m_line)
  );

  readline_arbiter #(.FIXED_PRIO(1), .LINE_LSB(4)) u_fix (
    .clk(clk), .rst(rst),
    .req0_readline_do(f_do[0]), .req0_readline_address(f_addr[0]),
    .req0_readline_done(f0_done), .req0_readline_line(f0_line),
    .req1_readline_do(f_do[1]), .req1_readline_address(f_addr[1]),
    .req1_readline_done(f1_done), .req1_readline_line(f1_line),
    .resp_readline_do(f_mdo), .resp_readline_address(f_maddr),
    .resp_readline_done(f_mdone), .resp_readline_line(f_mline)
  );

  int errs = 0;
  int checks = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] rand_line();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r = {r[95:0], 32'($urandom)};
    return r;
  endfunction

  function automatic logic [31:0] new_addr(input int p);
    logic [31:0] a;
    a = $urandom;
    a[31] = (p != 0);  // port 1 lives in the upper half so the address identifies the owner
    return a;
  endfunction

  // Reference model: one outstanding read, tie goes to the port not served last.
  typedef struct {
    int           port;
    logic [127:0] line;
  } done_t;

  logic [31:0] exp_req_q [$];
  done_t       exp_done_q [$];
  int          mdl_busy = -1;
  int          mdl_last = 1;
  logic        exp_mdo = 1'b0;

  always @(posedge clk) begin
    done_t e;
    int    n;
    #2;
    exp_mdo = (mdl_busy >= 0);
    if (mdl_busy >= 0 && m_done && rq_do[mdl_busy]) begin
      e.port = mdl_busy;
      e.line = m_line;
      exp_done_q.push_back(e);
    end
    if (rst) begin
      mdl_busy = -1;
      mdl_last = 1;
    end else if (mdl_busy >= 0) begin
      if (m_done) mdl_busy = -1;
    end else if (rq_do[0] || rq_do[1]) begin
      if (rq_do[0] && rq_do[1]) n = 1 - mdl_last;
      else n = rq_do[0] ? 0 : 1;
      mdl_busy = n;
      mdl_last = n;
      exp_req_q.push_back(rq_addr[n] & 32'hFFFF_FFF0);
    end
  end

  logic        prev_mdo = 1'b0;
  logic [31:0] cur_addr = '0;

  always @(negedge clk) begin
    done_t e;
    chk("resp_do", m_do, exp_mdo);
    if (m_do && !prev_mdo) begin
      chk("req_expected", exp_req_q.size() != 0, 1);
      if (exp_req_q.size() != 0) cur_addr = exp_req_q.pop_front();
    end
    if (m_do) chk("resp_addr", m_addr, cur_addr);
    prev_mdo = m_do;
    chk("done_exclusive", r0_done && r1_done, 0);
    if (r0_done || r1_done) begin
      chk("done_expected", exp_done_q.size() != 0, 1);
      if (exp_done_q.size() != 0) begin
        e = exp_done_q.pop_front();
        chk("done_port", r1_done, e.port == 1);
        chk("done_line", r1_done ? r1_line : r0_line, e.line);
      end
    end
    chk("done_missing", exp_done_q.size(), 0);
    exp_done_q.delete();
  end

  logic d [2];
  logic fd0, fd1;
  logic mem_pend = 1'b0;
  int   mem_cnt = 0;
  logic spur_en = 1'b0;

  task automatic to_neg();
    @(negedge clk);
    d[0] = r0_done;
    d[1] = r1_done;
    fd0  = f0_done;
    fd1  = f1_done;
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    to_neg();
    to_pos();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic mem_step();
    m_done = 1'b0;
    if (!mem_pend && m_do) begin
      mem_pend = 1'b1;
      mem_cnt  = $urandom_range(3, 0);
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        m_done   = 1'b1;
        m_line   = rand_line();
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end else if (spur_en && !m_do && $urandom_range(7, 0) == 0) begin
      m_done = 1'b1;
      m_line = rand_line();
    end
  endtask

  task automatic drain();
    rq_do[0] = 1'b0;
    rq_do[1] = 1'b0;
    spur_en  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mdl_busy < 0 && !mem_pend) break;
      cycle();
      mem_step();
    end
    cycle();
    m_done = 1'b0;
    chk("drain_resp_do", m_do, 0);
    chk("drain_req_q", exp_req_q.size(), 0);
  endtask

  initial begin
    logic [127:0] lv;
    logic         exp_b;
    logic         pm;
    int           c0, c1;
    logic         got1;

    rst = 1'b1;
    m_done = 1'b0; m_line = '0;
    for (int p = 0; p < 2; p++) begin
      rq_do[p] = 1'b0; rq_addr[p] = '0; f_do[p] = 1'b0; f_addr[p] = '0;
    end
    f_mdone = 1'b0; f_mline = '0;
    cycle(); cycle(); cycle();
    rst = 1'b0;
    chk("rst_resp_do", m_do, 0);
    chk("rst_resp_addr", m_addr, 0);
    chk("rst_done0", r0_done, 0);
    chk("rst_done1", r1_done, 0);

    // Single read on port 0.
    lv = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    rq_do[0] = 1'b1; rq_addr[0] = 32'h0001_2345;
    cycle();
    chk("single_do", m_do, 1);
    chk("single_addr", m_addr, 32'h0001_2340);
    m_done = 1'b1; m_line = lv;
    to_neg();
    chk("single_done0", r0_done, 1);
    chk("single_line0", r0_line, lv);
    chk("single_done1", r1_done, 0);
    to_pos();
    m_done = 1'b0; rq_do[0] = 1'b0;
    cycle();
    chk("single_idle", m_do, 0);

    // Simultaneous requests straight out of reset: port 0 then port 1.
    do_reset();
    rq_do[0] = 1'b1; rq_addr[0] = 32'h0000_4010;
    rq_do[1] = 1'b1; rq_addr[1] = 32'h0000_8000;
    cycle();
    chk("rr_first_addr", m_addr, 32'h0000_4010);
    m_done = 1'b1; m_line = rand_line();
    cycle();
    m_done = 1'b0; rq_do[0] = 1'b0;
    chk("rr_gap", m_do, 0);
    cycle();
    chk("rr_second_do", m_do, 1);
    chk("rr_second_addr", m_addr, 32'h0000_8000);
    m_done = 1'b1; m_line = rand_line();
    to_neg();
    chk("rr_second_done1", r1_done, 1);
    to_pos();
    m_done = 1'b0; rq_do[1] = 1'b0;
    cycle();

    // Port 1 abandons mid-read; completion is swallowed, port 0 then served.
    rq_do[1] = 1'b1; rq_addr[1] = 32'h8000_1230;
    cycle(); cycle(); cycle();
    rq_do[1] = 1'b0;
    cycle();
    m_done = 1'b1; m_line = rand_line();
    to_neg();
    chk("abandon_no_done1", r1_done, 0);
    chk("abandon_no_done0", r0_done, 0);
    to_pos();
    m_done = 1'b0; rq_do[0] = 1'b1; rq_addr[0] = 32'h0000_7770;
    cycle();
    chk("abandon_next_addr", m_addr, 32'h0000_7770);
    m_done = 1'b1; m_line = rand_line();
    to_neg();
    chk("abandon_next_done0", r0_done, 1);
    to_pos();
    m_done = 1'b0; rq_do[0] = 1'b0;
    cycle();

    // Reset while a read is outstanding; the late completion must go nowhere.
    rq_do[0] = 1'b1; rq_addr[0] = 32'h0000_1238;
    cycle(); cycle();
    rst = 1'b1; rq_do[0] = 1'b0;
    cycle();
    rst = 1'b0;
    chk("midrst_do", m_do, 0);
    cycle();
    m_done = 1'b1; m_line = rand_line();
    to_neg();
    chk("midrst_late_done0", r0_done, 0);
    to_pos();
    m_done = 1'b0;
    cycle();
    chk("midrst_idle", m_do, 0);

    // Spurious completion while idle, then address wiggle during a read.
    m_done = 1'b1; m_line = rand_line();
    to_neg();
    chk("spur_done0", r0_done, 0);
    chk("spur_done1", r1_done, 0);
    to_pos();
    m_done = 1'b0;
    chk("spur_idle", m_do, 0);
    rq_do[1] = 1'b1; rq_addr[1] = 32'h8000_5550;
    cycle();
    rq_addr[1] = 32'h8123_4567;
    cycle();
    chk("wiggle_addr", m_addr, 32'h8000_5550);
    m_done = 1'b1; m_line = rand_line();
    cycle();
    m_done = 1'b0; rq_do[1] = 1'b0;
    cycle();

    // Both ports requesting continuously must alternate 0,1,0,1.
    do_reset();
    exp_b = 1'b0; pm = 1'b0;
    rq_do[0] = 1'b1; rq_addr[0] = new_addr(0);
    rq_do[1] = 1'b1; rq_addr[1] = new_addr(1);
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (m_do && !pm) begin
        chk("alt_order", m_addr[31], exp_b);
        exp_b = ~exp_b;
      end
      pm = m_do;
      for (int p = 0; p < 2; p++) if (d[p]) rq_addr[p] = new_addr(p);
      mem_step();
    end
    drain();

    // Random traffic with abandons, wiggles and stray completions.
    spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      mem_step();
      for (int p = 0; p < 2; p++) begin
        if (rq_do[p]) begin
          if (d[p]) begin
            if ($urandom_range(1, 0) == 0) rq_do[p] = 1'b0;
            else rq_addr[p] = new_addr(p);
          end else if ($urandom_range(31, 0) == 0) begin
            rq_do[p] = 1'b0;
          end else if ($urandom_range(15, 0) == 0) begin
            rq_addr[p] = new_addr(p);
          end
        end else if ($urandom_range(2, 0) == 0) begin
          rq_do[p] = 1'b1;
          rq_addr[p] = new_addr(p);
        end
      end
    end
    drain();

    // Fixed priority: a persistent port 0 starves port 1.
    c0 = 0; c1 = 0; got1 = 1'b0;
    f_do[0] = 1'b1; f_addr[0] = 32'h0000_1000;
    f_do[1] = 1'b1; f_addr[1] = 32'h8000_2000;
    for (int i = 0; i < 40; i++) begin
      to_neg();
      c0 += int'(fd0);
      c1 += int'(fd1);
      to_pos();
      if (f_mdo) chk("fix_addr", f_maddr, 32'h0000_1000);
      f_mdone = f_mdo && !f_mdone;
      f_mline = rand_line();
    end
    chk("fix_p0_served", c0 >= 15, 1);
    chk("fix_p1_starved", c1, 0);
    f_do[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      to_neg();
      if (fd1) got1 = 1'b1;
      to_pos();
      if (got1) break;
      f_mdone = f_mdo && !f_mdone;
    end
    chk("fix_p1_after_p0", got1, 1);
    f_do[1] = 1'b0; f_mdone = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
